srrc_gold_tx_flt: RTL and testbench

// - Full-precision ("gold") square-root-raised-cosine pulse-shaping FIR for the 4-ASK transmitter.
// - Sits after the symbol mapper. Runs at 4 samples/symbol on sam_clk_en from clk_gen
//   (sam_clk_en: 1 of 4 sys_clk; sym_clk_en: 1 of 16).
// - Does no truncation or rounding. It is the bit-exact reference that reduced-precision filters are scored against.

---
 rtl/srrc_pkg.sv | 48 ++++
 rtl/srrc_gold_coef_rom.sv | 43 ++++
 rtl/srrc_gold_tx_flt.sv | 85 ++++++++
 tb/tb_srrc_gold_tx_flt.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/srrc_pkg.sv
// -----------------------------------------------------------------------------
// srrc_pkg
// Shared constants for the 4-ASK transmit pulse-shaping filters: tap count,
// centre index, datapath widths, the 21 unique SRRC coefficients (beta=0.25,
// 4 samples/symbol, 10-symbol span, centre scaled to 65536 = 0.5 in 1s17)
// and the 4-ASK symbol levels in 1s17.
// No ports (package).
// -----------------------------------------------------------------------------
package srrc_pkg;

    localparam int NUM_TAPS = 41;
    localparam int CTR      = 20;
    localparam int IN_W     = 18;
    localparam int COEF_W   = 18;
    localparam int OUT_W    = 94;
    // Pre-adder keeps the carry of two 18-bit samples; product is exact.
    localparam int PRE_W    = IN_W + 1;
    localparam int PROD_W   = PRE_W + COEF_W;

    // h[k] = h[40-k]; only the outer half plus the centre are stored.
    localparam logic signed [COEF_W-1:0] H_00 = -18'sd460;
    localparam logic signed [COEF_W-1:0] H_01 = -18'sd701;
    localparam logic signed [COEF_W-1:0] H_02 = -18'sd180;
    localparam logic signed [COEF_W-1:0] H_03 =  18'sd785;
    localparam logic signed [COEF_W-1:0] H_04 =  18'sd1302;
    localparam logic signed [COEF_W-1:0] H_05 =  18'sd609;
    localparam logic signed [COEF_W-1:0] H_06 = -18'sd1122;
    localparam logic signed [COEF_W-1:0] H_07 = -18'sd2619;
    localparam logic signed [COEF_W-1:0] H_08 = -18'sd2301;
    localparam logic signed [COEF_W-1:0] H_09 =  18'sd369;
    localparam logic signed [COEF_W-1:0] H_10 =  18'sd4006;
    localparam logic signed [COEF_W-1:0] H_11 =  18'sd5773;
    localparam logic signed [COEF_W-1:0] H_12 =  18'sd3254;
    localparam logic signed [COEF_W-1:0] H_13 = -18'sd3374;
    localparam logic signed [COEF_W-1:0] H_14 = -18'sd10447;
    localparam logic signed [COEF_W-1:0] H_15 = -18'sd12190;
    localparam logic signed [COEF_W-1:0] H_16 = -18'sd3941;
    localparam logic signed [COEF_W-1:0] H_17 =  18'sd14592;
    localparam logic signed [COEF_W-1:0] H_18 =  18'sd38144;
    localparam logic signed [COEF_W-1:0] H_19 =  18'sd57859;
    localparam logic signed [COEF_W-1:0] H_20 =  18'sd65536;

    localparam logic signed [IN_W-1:0] SYMBOL_P2 =  18'sd98304;
    localparam logic signed [IN_W-1:0] SYMBOL_P1 =  18'sd32768;
    localparam logic signed [IN_W-1:0] SYMBOL_M1 = -18'sd32768;
    localparam logic signed [IN_W-1:0] SYMBOL_M2 = -18'sd98304;

endpackage

// File: rtl/srrc_gold_coef_rom.sv
// -----------------------------------------------------------------------------
// srrc_gold_coef_rom
// Combinational lookup of the unique SRRC coefficients.
// Ports:
//   idx_i   in  5   coefficient index 0..20 (20 = centre tap)
//   coef_o  out 18  signed 1s17 coefficient h[idx_i]; 0 for out-of-range index
// -----------------------------------------------------------------------------
module srrc_gold_coef_rom
    import srrc_pkg::*;
(
    input  logic        [4:0]        idx_i,
    output logic signed [COEF_W-1:0] coef_o
);

    always_comb begin
        coef_o = '0;
        case (idx_i)
            5'd0:    coef_o = H_00;
            5'd1:    coef_o = H_01;
            5'd2:    coef_o = H_02;
            5'd3:    coef_o = H_03;
            5'd4:    coef_o = H_04;
            5'd5:    coef_o = H_05;
            5'd6:    coef_o = H_06;
            5'd7:    coef_o = H_07;
            5'd8:    coef_o = H_08;
            5'd9:    coef_o = H_09;
            5'd10:   coef_o = H_10;
            5'd11:   coef_o = H_11;
            5'd12:   coef_o = H_12;
            5'd13:   coef_o = H_13;
            5'd14:   coef_o = H_14;
            5'd15:   coef_o = H_15;
            5'd16:   coef_o = H_16;
            5'd17:   coef_o = H_17;
            5'd18:   coef_o = H_18;
            5'd19:   coef_o = H_19;
            5'd20:   coef_o = H_20;
            default: coef_o = '0;
        endcase
    end

endmodule

// File: rtl/srrc_gold_tx_flt.sv
// -----------------------------------------------------------------------------
// srrc_gold_tx_flt
// Full-precision 41-tap symmetric SRRC pulse-shaping FIR for the 4-ASK
// transmitter. No truncation or rounding anywhere: this is the bit-exact
// reference that reduced-precision filters are scored against.
// Ports:
//   sys_clk     in   1   system clock, all state on rising edge
//   sam_clk_en  in   1   sample-rate enable, shifts the delay line
//   sym_clk_en  in   1   symbol-rate enable, not used by this block
//   reset       in   1   synchronous active-high, clears delay line and y
//   x_in        in  18   signed 1s17 input sample
//   y           out 94   signed full-precision filtered sample
// -----------------------------------------------------------------------------
module srrc_gold_tx_flt
    import srrc_pkg::*;
(
    input  logic                    sys_clk,
    input  logic                    sam_clk_en,
    input  logic                    sym_clk_en,
    input  logic                    reset,
    input  logic signed [IN_W-1:0]  x_in,
    output logic signed [OUT_W-1:0] y
);

    // The symbol enable is part of the common filter interface only.
    logic unused_sym_clk_en;
    assign unused_sym_clk_en = sym_clk_en;

    logic signed [IN_W-1:0]   d_q    [NUM_TAPS];
    logic signed [COEF_W-1:0] coef   [CTR+1];
    logic signed [PRE_W-1:0]  pre_s  [CTR+1];
    logic signed [PROD_W-1:0] prod_s [CTR+1];
    logic signed [OUT_W-1:0]  y_d;
    logic signed [OUT_W-1:0]  y_q;

    // Constant indices: each ROM collapses to a fixed coefficient.
    for (genvar g = 0; g <= CTR; g++) begin : g_rom
        srrc_gold_coef_rom u_rom (
            .idx_i  (5'(g)),
            .coef_o (coef[g])
        );
    end

    // Fold the symmetric taps so only 21 multipliers are needed.
    always_comb begin
        for (int k = 0; k < CTR; k++) begin
            pre_s[k] = PRE_W'(d_q[k]) + PRE_W'(d_q[NUM_TAPS-1-k]);
        end
        pre_s[CTR] = PRE_W'(d_q[CTR]);
    end

    always_comb begin
        for (int k = 0; k <= CTR; k++) begin
            prod_s[k] = PROD_W'(pre_s[k]) * PROD_W'(coef[k]);
        end
    end

    always_comb begin
        y_d = '0;
        for (int k = 0; k <= CTR; k++) begin
            y_d = y_d + OUT_W'(prod_s[k]);
        end
    end

    // y is re-evaluated every edge so it follows the delay line one cycle late.
    always_ff @(posedge sys_clk) begin
        if (reset) begin
            for (int k = 0; k < NUM_TAPS; k++) begin
                d_q[k] <= '0;
            end
            y_q <= '0;
        end else begin
            if (sam_clk_en) begin
                d_q[0] <= x_in;
                for (int k = 1; k < NUM_TAPS; k++) begin
                    d_q[k] <= d_q[k-1];
                end
            end
            y_q <= y_d;
        end
    end

    assign y = y_q;

endmodule

// File: tb/tb_srrc_gold_tx_flt.sv
// -----------------------------------------------------------------------------
// tb_srrc_gold_tx_flt
// Self-checking bench: the reference model derives the 41 coefficients from
// the SRRC formula and computes y as a direct-form convolution over a history
// of accepted samples.
// -----------------------------------------------------------------------------
module tb_srrc_gold_tx_flt;

    logic               sys_clk = 1'b0;
    logic               sam_clk_en;
    logic               sym_clk_en;
    logic               reset;
    logic signed [17:0] x_in;
    logic signed [93:0] y;

    int checks   = 0;
    int failures = 0;

    longint h    [0:40];
    longint hist [0:40];
    longint sumh;

    always #5 sys_clk = ~sys_clk;

    srrc_gold_tx_flt dut (
        .sys_clk    (sys_clk),
        .sam_clk_en (sam_clk_en),
        .sym_clk_en (sym_clk_en),
        .reset      (reset),
        .x_in       (x_in),
        .y          (y)
    );

    task automatic check_val(input string tag, input logic signed [93:0] got,
                             input logic signed [93:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    // SRRC pulse, beta=0.25, t = n/4 symbol periods.
    function automatic real p_srrc(input int n);
        real pi;
        real b;
        real t;
        real fbt;
        pi = 3.14159265358979323846;
        b  = 0.25;
        t  = n / 4.0;
        if (n == 0) return 1.0 - b + 4.0 * b / pi;
        if (n == 4 || n == -4)
            return (b / $sqrt(2.0)) * ((1.0 + 2.0 / pi) * $sin(pi / (4.0 * b)) +
                                       (1.0 - 2.0 / pi) * $cos(pi / (4.0 * b)));
        fbt = 4.0 * b * t;
        return ($sin(pi * t * (1.0 - b)) + fbt * $cos(pi * t * (1.0 + b))) /
               (pi * t * (1.0 - fbt * fbt));
    endfunction

    task automatic clear_model();
        for (int k = 0; k < 41; k++) hist[k] = 0;
    endtask

    task automatic shift_model(input longint x);
        for (int k = 40; k > 0; k--) hist[k] = hist[k-1];
        hist[0] = x;
    endtask

    function automatic longint model_y();
        longint acc;
        acc = 0;
        for (int k = 0; k < 41; k++) acc += h[k] * hist[k];
        return acc;
    endfunction

    // One sample period: shift on the first edge, scramble x_in while the
    // enable is low, return at a negedge well after y has settled.
    task automatic sample(input logic signed [17:0] x);
        @(negedge sys_clk);
        x_in       = x;
        sam_clk_en = 1'b1;
        sym_clk_en = 1'($urandom);
        @(negedge sys_clk);
        shift_model(longint'(x));
        sam_clk_en = 1'b0;
        x_in       = 18'($urandom);
        sym_clk_en = 1'($urandom);
        @(negedge sys_clk);
        x_in       = 18'($urandom);
        sym_clk_en = 1'($urandom);
        @(negedge sys_clk);
    endtask

    task automatic do_reset(input int n);
        @(negedge sys_clk);
        reset = 1'b1;
        repeat (n) begin
            x_in       = 18'($urandom);
            sam_clk_en = 1'($urandom);
            sym_clk_en = 1'($urandom);
            @(negedge sys_clk);
        end
        reset      = 1'b0;
        sam_clk_en = 1'b0;
        clear_model();
    endtask

    task automatic run_const(input string tag, input logic signed [17:0] x, input int n);
        for (int i = 0; i < n; i++) begin
            sample(x);
            check_val(tag, y, model_y());
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout checks=%0d", checks);
        $fatal(1);
    end

    initial begin
        logic signed [17:0] r;
        reset      = 1'b1;
        sam_clk_en = 1'b0;
        sym_clk_en = 1'b0;
        x_in       = '0;
        sumh       = 0;
        for (int k = 0; k < 41; k++) begin
            h[k] = longint'($floor(65536.0 * p_srrc(k - 20) / p_srrc(0) + 0.5));
            sumh += h[k];
        end
        clear_model();

        // Reset with activity on the inputs.
        do_reset(2);
        check_val("rst_y", y, 0);
        @(negedge sys_clk);
        check_val("rst_y_hold", y, 0);
        for (int k = 0; k < 41; k++) check_val("rst_d", dut.d_q[k], 0);

        // Impulse response.
        for (int j = 0; j < 45; j++) begin
            sample((j == 0) ? 18'sd98304 : 18'sd0);
            check_val("impulse", y, model_y());
            if (j == 20) check_val("imp_ctr", y, 64'sd6442450944);
            if (j >= 41) check_val("imp_tail", y, 0);
        end

        // DC settling.
        do_reset(2);
        run_const("dc", 18'sd32768, 45);
        check_val("dc_final", y, 32768 * sumh);

        // Full-scale extremes.
        do_reset(2);
        run_const("ext_neg", -18'sd131072, 42);
        check_val("ext_neg_final", y, -131072 * sumh);
        do_reset(2);
        run_const("ext_pos", 18'sd131071, 42);
        check_val("ext_pos_final", y, 131071 * sumh);

        // Random samples and random symbol levels.
        for (int i = 0; i < 80; i++) begin
            if (i % 2 == 0) begin
                r = 18'($urandom);
            end else begin
                case ($urandom_range(3, 0))
                    0:       r =  18'sd98304;
                    1:       r =  18'sd32768;
                    2:       r = -18'sd32768;
                    default: r = -18'sd98304;
                endcase
            end
            sample(r);
            check_val("random", y, model_y());
        end

        // Enable gating: input and symbol enable wiggle, nothing moves.
        for (int i = 0; i < 8; i++) begin
            @(negedge sys_clk);
            sam_clk_en = 1'b0;
            x_in       = 18'($urandom);
            sym_clk_en = ~sym_clk_en;
            check_val("gate_hold", y, model_y());
        end

        // Mid-stream reset at j=10 of an impulse response.
        do_reset(1);
        for (int j = 0; j <= 10; j++) begin
            sample((j == 0) ? 18'sd98304 : 18'sd0);
            check_val("mid_pre", y, model_y());
        end
        @(negedge sys_clk);
        reset      = 1'b1;
        sam_clk_en = 1'b1;
        x_in       = 18'($urandom);
        @(negedge sys_clk);
        reset      = 1'b0;
        sam_clk_en = 1'b0;
        clear_model();
        check_val("mid_rst_y", y, 0);
        for (int j = 0; j < 6; j++) begin
            sample(18'sd0);
            check_val("mid_post", y, model_y());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
